// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, FSM state type and error-bit positions for the
// sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b0111;
    localparam logic [3:0] OP_MOD = 4'b1000;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} aluState_t;

    localparam int ERR_OVF  = 0;
    localparam int ERR_DIV0 = 1;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the operand register file, the sequential
// ALU and the result bus.
interface seq_alu_if #(
    parameter int WIDTH = 16
);

    logic                 Start;
    logic [3:0]           OpCode;
    logic [WIDTH-1:0]     InputA;
    logic [WIDTH-1:0]     InputB;
    logic                 Busy;
    logic                 Done;
    logic [2*WIDTH-1:0]   Result;
    logic [1:0]           Error;

    modport master (
        output Start, OpCode, InputA, InputB,
        input  Busy, Done, Result, Error
    );

    modport slave (
        input  Start, OpCode, InputA, InputB,
        output Busy, Done, Result, Error
    );

endinterface

// File: rtl/seq_alu_divider.sv
// Unsigned restoring divider datapath: load captures the operands, each enable
// retires one quotient bit, MSB first.
module seq_alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] nextQuotient,
    output logic [WIDTH-1:0] nextRemainder
);

    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH:0]   shifted;
    logic             fits;

    // The partial remainder stays below the divisor, so once the trial
    // subtraction fits the difference always fits back into WIDTH bits.
    always_comb begin
        shifted       = {remainder, quotient[WIDTH-1]};
        fits          = (shifted >= {1'b0, divisorReg});
        nextRemainder = fits ? (shifted[WIDTH-1:0] - divisorReg) : shifted[WIDTH-1:0];
        nextQuotient  = {quotient[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quotient   <= '0;
            remainder  <= '0;
            divisorReg <= '0;
        end else if (load) begin
            quotient   <= dividend;
            remainder  <= '0;
            divisorReg <= divisor;
        end else if (enable) begin
            quotient   <= nextQuotient;
            remainder  <= nextRemainder;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle add/sub/mul/div/mod ALU: one operation per accepted Start,
// registered Result/Error held until the next operation completes.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    seq_alu_if.slave      bus
);

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    aluState_t            state, nextState;
    logic [CW-1:0]        iterCount;
    logic                 lastIter;
    logic [2*WIDTH-1:0]   resultReg, resultNext;
    logic [1:0]           errorReg, errorNext;
    logic                 writeOut, loadMul, loadDiv, divEnable;
    logic                 isModReg;
    logic [2*WIDTH-1:0]   mcand, acc, mulSum;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     bOperand, sum, quotient, remainder;
    logic                 isSub, carryOut, carryIn, overflow;

    // Overflow is the carry into the MSB xor the carry out of it; the carry in
    // is recovered from the MSB sum bit rather than a second adder.
    always_comb begin
        isSub               = (bus.OpCode == OP_SUB);
        bOperand            = isSub ? ~bus.InputB : bus.InputB;
        {carryOut, sum}     = {1'b0, bus.InputA} + {1'b0, bOperand} + {{WIDTH{1'b0}}, isSub};
        carryIn             = sum[WIDTH-1] ^ bus.InputA[WIDTH-1] ^ bOperand[WIDTH-1];
        overflow            = carryIn ^ carryOut;
        mulSum              = acc + (mplier[0] ? mcand : '0);
        lastIter            = (iterCount == LAST_ITER);
    end

    always_comb begin
        nextState  = state;
        resultNext = resultReg;
        errorNext  = errorReg;
        writeOut   = 1'b0;
        loadMul    = 1'b0;
        loadDiv    = 1'b0;
        divEnable  = 1'b0;
        case (state)
            IDLE, DONE: begin
                nextState = IDLE;
                if (bus.Start) begin
                    case (bus.OpCode)
                        OP_ADD, OP_SUB: begin
                            writeOut            = 1'b1;
                            resultNext          = {{WIDTH{sum[WIDTH-1]}}, sum};
                            errorNext           = 2'b00;
                            errorNext[ERR_OVF]  = overflow;
                            nextState           = DONE;
                        end
                        OP_MUL: begin
                            loadMul   = 1'b1;
                            nextState = MUL;
                        end
                        OP_DIV, OP_MOD: begin
                            if (bus.InputB == '0) begin
                                writeOut            = 1'b1;
                                errorNext           = 2'b00;
                                errorNext[ERR_DIV0] = 1'b1;
                                resultNext          = (bus.OpCode == OP_DIV) ? '1
                                                      : {{WIDTH{1'b0}}, bus.InputA};
                                nextState           = DONE;
                            end else begin
                                loadDiv   = 1'b1;
                                nextState = DIV;
                            end
                        end
                        default: begin
                            writeOut   = 1'b1;
                            resultNext = '0;
                            errorNext  = 2'b00;
                            nextState  = DONE;
                        end
                    endcase
                end
            end
            MUL: begin
                if (lastIter) begin
                    writeOut   = 1'b1;
                    resultNext = mulSum;
                    errorNext  = 2'b00;
                    nextState  = DONE;
                end
            end
            DIV: begin
                divEnable = 1'b1;
                if (lastIter) begin
                    writeOut   = 1'b1;
                    resultNext = {{WIDTH{1'b0}}, isModReg ? remainder : quotient};
                    errorNext  = 2'b00;
                    nextState  = DONE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The final iteration edge writes the result straight from the
    // combinational next values, so Result lands together with DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resultReg <= '0;
            errorReg  <= 2'b00;
            iterCount <= '0;
            isModReg  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            if (writeOut) begin
                resultReg <= resultNext;
                errorReg  <= errorNext;
            end
            if (loadMul || loadDiv) begin
                iterCount <= '0;
            end else if (state == MUL || state == DIV) begin
                iterCount <= lastIter ? '0 : iterCount + 1'b1;
            end
            if (loadDiv) begin
                isModReg <= (bus.OpCode == OP_MOD);
            end
            if (loadMul) begin
                mcand  <= {{WIDTH{1'b0}}, bus.InputA};
                mplier <= bus.InputB;
                acc    <= '0;
            end else if (state == MUL) begin
                acc    <= mulSum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    seq_alu_divider #(.WIDTH(WIDTH)) divider (
        .clk           (clk),
        .reset         (reset),
        .load          (loadDiv),
        .enable        (divEnable),
        .dividend      (bus.InputA),
        .divisor       (bus.InputB),
        .nextQuotient  (quotient),
        .nextRemainder (remainder)
    );

    assign bus.Busy   = (state == MUL) || (state == DIV);
    assign bus.Done   = (state == DONE);
    assign bus.Result = resultReg;
    assign bus.Error  = errorReg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu (WIDTH=16) plus hand-written
// sequences for Start-while-busy, Start-in-DONE and mid-operation reset.
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] expResult;
        logic [1:0]  expError;
        int          expOffset;
    } vector_t;

    localparam int NV = 14;

    logic    clk;
    logic    reset;
    int      errors;
    int      checks;
    vector_t vecs [NV];

    seq_alu_if #(.WIDTH(16)) bus ();

    seq_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one request and returns how many edges after the accepting edge
    // Done was first seen; inputs are scrambled right after acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output int doneOffset, output logic busyEarly);
        @(negedge clk);
        bus.OpCode = op;
        bus.InputA = a;
        bus.InputB = b;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start  = 1'b0;
        bus.OpCode = 4'b1111;
        bus.InputA = ~a;
        bus.InputB = ~b;
        busyEarly  = bus.Busy;
        doneOffset = 0;
        while (!bus.Done && doneOffset < 40) begin
            @(posedge clk);
            #1;
            doneOffset++;
        end
    endtask

    initial begin
        int   off;
        logic busyE;
        logic sawDone;

        errors = 0;
        checks = 0;
        vecs[0]  = '{OP_ADD, 16'd100,    16'd150,    32'd250,        2'b00, 0};
        vecs[1]  = '{OP_SUB, 16'd200,    16'd87,     32'd113,        2'b00, 0};
        vecs[2]  = '{OP_ADD, 16'd18500,  16'd21230,  32'hFFFF9B32,   2'b01, 0};
        vecs[3]  = '{OP_SUB, 16'hC000,   16'h6000,   32'h00006000,   2'b01, 0};
        vecs[4]  = '{OP_SUB, 16'd5,      16'd10,     32'hFFFFFFFB,   2'b00, 0};
        vecs[5]  = '{OP_ADD, 16'h8000,   16'hFFFF,   32'h00007FFF,   2'b01, 0};
        vecs[6]  = '{OP_MUL, 16'd221,    16'd116,    32'd25636,      2'b00, 16};
        vecs[7]  = '{OP_MUL, 16'hFFFF,   16'hFFFF,   32'hFFFE0001,   2'b00, 16};
        vecs[8]  = '{OP_DIV, 16'd29450,  16'd16450,  32'd1,          2'b00, 16};
        vecs[9]  = '{OP_MOD, 16'd32400,  16'd16200,  32'd0,          2'b00, 16};
        vecs[10] = '{OP_DIV, 16'd21,     16'd0,      32'hFFFFFFFF,   2'b10, 0};
        vecs[11] = '{OP_MOD, 16'd169,    16'd0,      32'd169,        2'b10, 0};
        vecs[12] = '{OP_DIV, 16'd1000,   16'd7,      32'd142,        2'b00, 16};
        vecs[13] = '{4'b0000, 16'd5,     16'd3,      32'd0,          2'b00, 0};

        bus.Start  = 1'b0;
        bus.OpCode = 4'b0000;
        bus.InputA = '0;
        bus.InputB = '0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset Busy",   bus.Busy,   0);
        checkOutput("reset Done",   bus.Done,   0);
        checkOutput("reset Result", bus.Result, 0);
        checkOutput("reset Error",  bus.Error,  0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, off, busyE);
            checkOutput($sformatf("v%0d latency", i), off, vecs[i].expOffset);
            checkOutput($sformatf("v%0d busy", i), busyE, (vecs[i].expOffset != 0));
            checkOutput($sformatf("v%0d result", i), bus.Result, vecs[i].expResult);
            checkOutput($sformatf("v%0d error", i), bus.Error, vecs[i].expError);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d done pulse", i), bus.Done, 0);
        end

        // A different request held during a multiply must be dropped.
        @(negedge clk);
        bus.OpCode = OP_MUL;
        bus.InputA = 16'd300;
        bus.InputB = 16'd200;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        off = 0;
        while (!bus.Done && off < 40) begin
            @(posedge clk);
            #1;
            off++;
            if (off == 3) begin
                bus.Start  = 1'b1;
                bus.OpCode = OP_ADD;
                bus.InputA = 16'd1;
                bus.InputB = 16'd1;
            end
            if (off == 10) bus.Start = 1'b0;
        end
        checkOutput("busy-start latency", off, 16);
        checkOutput("busy-start result", bus.Result, 32'd60000);
        checkOutput("busy-start error", bus.Error, 0);
        @(posedge clk);
        #1;
        checkOutput("busy-start no second done", bus.Done, 0);

        // Start presented during the DONE cycle is accepted on the next edge.
        applyStimulus(OP_ADD, 16'd1, 16'd2, off, busyE);
        checkOutput("done-cycle first result", bus.Result, 32'd3);
        bus.OpCode = OP_MUL;
        bus.InputA = 16'd221;
        bus.InputB = 16'd116;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        checkOutput("done-cycle accepted busy", bus.Busy, 1);
        off = 0;
        while (!bus.Done && off < 40) begin
            @(posedge clk);
            #1;
            off++;
        end
        checkOutput("done-cycle latency", off, 16);
        checkOutput("done-cycle result", bus.Result, 32'd25636);

        // Reset in the middle of a divide aborts it without a Done.
        @(negedge clk);
        bus.OpCode = OP_DIV;
        bus.InputA = 16'd29450;
        bus.InputB = 16'd16450;
        bus.Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("pre-reset busy", bus.Busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("abort Busy",   bus.Busy,   0);
        checkOutput("abort Done",   bus.Done,   0);
        checkOutput("abort Result", bus.Result, 0);
        checkOutput("abort Error",  bus.Error,  0);
        @(negedge clk);
        reset   = 1'b0;
        sawDone = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.Done) sawDone = 1'b1;
        end
        checkOutput("abort no done", sawDone, 0);
        applyStimulus(OP_ADD, 16'd3, 16'd4, off, busyE);
        checkOutput("post-reset latency", off, 0);
        checkOutput("post-reset result", bus.Result, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
